// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode/funct constants and enums for the decode/execute stage
// Contents: opcode and funct encodings, ALU operation enum, stage FSM state enum.
package proc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  typedef enum logic {
    EXEC,
    LOAD_WB
  } de_state_t;

endpackage

// File: rtl/decode_execute_regfile.sv
// rtl/decode_execute_regfile.sv - register file, 2 combinational read ports, 1 synchronous write port
// Ports:
//   clk, rst_n           : clock, synchronous active-low clear of every register
//   raddr_a/raddr_b      : read addresses; rdata_a/rdata_b return the current contents
//   we, waddr, wdata     : write port, takes effect on posedge (r0 writes dropped)
module decode_execute_regfile
  import proc_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    raddr_a,
  input  logic [4:0]    raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  input  logic          we,
  input  logic [4:0]    waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] regs [NREG];

  // Reads see the pre-write value in the cycle a write is issued.
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/decode_execute.sv
// rtl/decode_execute.sv - decode/execute/memory/writeback stage of the 2-stage processor
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   instr, pc, instr_valid    : instruction from fetch and its PC
//   branch, zero, jump, stall : controls back to fetch (registered, held between instructions)
//   dmem_*                    : data-memory word address, store data, store/load strobes, load data
//   wb_valid, wb_reg, wb_data : writeback report
//   illegal                   : sticky unsupported-instruction flag
module decode_execute
  import proc_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int DW      = 32,
  parameter int DMEM_AW = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic [31:0]        pc,
  input  logic               instr_valid,
  output logic               branch,
  output logic               zero,
  output logic               jump,
  output logic               stall,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DW-1:0]      dmem_wdata,
  output logic               dmem_we,
  output logic               dmem_re,
  input  logic [DW-1:0]      dmem_rdata,
  output logic               wb_valid,
  output logic [4:0]         wb_reg,
  output logic [DW-1:0]      wb_data,
  output logic               illegal
);

  logic [5:0]    op, funct;
  logic [4:0]    rs, rt, rd;
  logic [DW-1:0] imm_ext;

  assign op      = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign funct   = instr[5:0];
  assign imm_ext = {{(DW-16){instr[15]}}, instr[15:0]};

  // ---------------- decode ----------------
  logic    legal, use_imm, wr_en, is_lw, is_sw, is_beq, is_j;
  logic [4:0] wr_reg;
  alu_op_t alu_op;

  always_comb begin
    legal   = 1'b0;
    use_imm = 1'b0;
    wr_en   = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_j    = 1'b0;
    wr_reg  = rd;
    alu_op  = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          F_ADD:   alu_op = ALU_ADD;
          F_SUB:   alu_op = ALU_SUB;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_SLT:   alu_op = ALU_SLT;
          default: legal  = 1'b0;
        endcase
        wr_en = legal;
      end
      OP_ADDI: begin
        legal   = 1'b1;
        use_imm = 1'b1;
        wr_en   = 1'b1;
        wr_reg  = rt;
      end
      OP_LW:   begin legal = 1'b1; is_lw  = 1'b1; end
      OP_SW:   begin legal = 1'b1; is_sw  = 1'b1; end
      OP_BEQ:  begin legal = 1'b1; is_beq = 1'b1; end
      OP_J:    begin legal = 1'b1; is_j   = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  // ---------------- register file ----------------
  logic [DW-1:0] rs_val, rt_val, rf_wdata;
  logic          rf_we;
  logic [4:0]    rf_waddr;

  decode_execute_regfile #(.NREG(NREG), .DW(DW)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_val),
    .rdata_b (rt_val),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  // ---------------- ALU and address ----------------
  logic [DW-1:0] alu_b, alu_res, addr_sum;

  assign alu_b    = use_imm ? imm_ext : rt_val;
  assign addr_sum = rs_val + imm_ext;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_SLT: alu_res = {{(DW-1){1'b0}}, ($signed(rs_val) < $signed(alu_b))};
      default: alu_res = '0;
    endcase
  end

  // Byte-offset bits, high address bits, shamt and pc are not used by this stage.
  logic unused_bits;
  assign unused_bits = &{1'b0, addr_sum, instr[10:6], pc};

  // ---------------- FSM ----------------
  de_state_t state_q, state_d;
  logic [4:0] load_rt_q, load_rt_d;

  logic               branch_d, zero_d, jump_d, stall_d, illegal_d;
  logic               dmem_we_d, dmem_re_d, wb_valid_d;
  logic [DMEM_AW-1:0] dmem_addr_d;
  logic [DW-1:0]      dmem_wdata_d, wb_data_d;
  logic [4:0]         wb_reg_d;

  always_comb begin
    state_d      = state_q;
    load_rt_d    = load_rt_q;
    branch_d     = branch;
    zero_d       = zero;
    jump_d       = jump;
    stall_d      = 1'b0;
    illegal_d    = illegal;
    dmem_we_d    = 1'b0;
    dmem_re_d    = 1'b0;
    dmem_addr_d  = dmem_addr;
    dmem_wdata_d = dmem_wdata;
    wb_valid_d   = 1'b0;
    wb_reg_d     = wb_reg;
    wb_data_d    = wb_data;
    rf_we        = 1'b0;
    rf_waddr     = wr_reg;
    rf_wdata     = alu_res;
    case (state_q)
      EXEC: begin
        if (instr_valid) begin
          // Branch/jump controls are re-evaluated by every accepted instruction.
          branch_d = is_beq;
          zero_d   = is_beq && (rs_val == rt_val);
          jump_d   = is_j;
          if (!legal) illegal_d = 1'b1;
          if (wr_en) begin
            rf_we      = 1'b1;
            wb_valid_d = 1'b1;
            wb_reg_d   = wr_reg;
            wb_data_d  = alu_res;
          end
          if (is_sw) begin
            dmem_we_d    = 1'b1;
            dmem_addr_d  = addr_sum[DMEM_AW+1:2];
            dmem_wdata_d = rt_val;
          end
          if (is_lw) begin
            dmem_re_d   = 1'b1;
            dmem_addr_d = addr_sum[DMEM_AW+1:2];
            stall_d     = 1'b1;
            load_rt_d   = rt;
            state_d     = LOAD_WB;
          end
        end
      end
      LOAD_WB: begin
        rf_we      = 1'b1;
        rf_waddr   = load_rt_q;
        rf_wdata   = dmem_rdata;
        wb_valid_d = 1'b1;
        wb_reg_d   = load_rt_q;
        wb_data_d  = dmem_rdata;
        state_d    = EXEC;
      end
      default: state_d = EXEC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EXEC;
      load_rt_q  <= '0;
      branch     <= 1'b0;
      zero       <= 1'b0;
      jump       <= 1'b0;
      stall      <= 1'b0;
      illegal    <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_re    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_reg     <= '0;
      wb_data    <= '0;
    end else begin
      state_q    <= state_d;
      load_rt_q  <= load_rt_d;
      branch     <= branch_d;
      zero       <= zero_d;
      jump       <= jump_d;
      stall      <= stall_d;
      illegal    <= illegal_d;
      dmem_we    <= dmem_we_d;
      dmem_re    <= dmem_re_d;
      dmem_addr  <= dmem_addr_d;
      dmem_wdata <= dmem_wdata_d;
      wb_valid   <= wb_valid_d;
      wb_reg     <= wb_reg_d;
      wb_data    <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_decode_execute.sv
// tb/tb_decode_execute.sv - directed self-checking bench for decode_execute
module tb_decode_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        branch, zero, jump, stall;
  logic [5:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we, dmem_re;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    bit          any_data;
  } wb_t;
  wb_t sb[$];

  always #5 clk = ~clk;

  decode_execute dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .pc          (pc),
    .instr_valid (instr_valid),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .stall       (stall),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_we     (dmem_we),
    .dmem_re     (dmem_re),
    .dmem_rdata  (dmem_rdata),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .illegal     (illegal)
  );

  function automatic logic [31:0] r_ins(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] f);
    return {6'b000000, s, t, d, 5'b00000, f};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] o, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {o, s, t, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d, input bit any_data);
    wb_t e;
    e.r = r;
    e.d = d;
    e.any_data = any_data;
    sb.push_back(e);
  endtask

  task automatic mon();
    wb_t e;
    if (wb_valid) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", {31'b0, wb_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_reg", {27'b0, wb_reg}, {27'b0, e.r});
        if (!e.any_data) chk("wb_data", wb_data, e.d);
      end
    end
  endtask

  task automatic cyc(input logic [31:0] ins, input logic v);
    @(negedge clk);
    instr       = ins;
    pc          = pc + 32'd4;
    instr_valid = v;
    @(posedge clk);
    #1;
    mon();
  endtask

  initial begin
    rst_n       = 1'b0;
    instr       = '0;
    pc          = '0;
    instr_valid = 1'b0;
    dmem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_stall",    {31'b0, stall},    32'd0);
    chk("rst_branch",   {31'b0, branch},   32'd0);
    chk("rst_jump",     {31'b0, jump},     32'd0);
    chk("rst_illegal",  {31'b0, illegal},  32'd0);
    chk("rst_dmem_we",  {31'b0, dmem_we},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU ops
    push(5'd1, 32'd5, 0);          cyc(i_ins(6'b001000, 5'd0, 5'd1, 16'd5), 1'b1);
    chk("addi_wb_valid", {31'b0, wb_valid}, 32'd1);
    push(5'd2, 32'hFFFF_FFFD, 0);  cyc(i_ins(6'b001000, 5'd0, 5'd2, 16'hFFFD), 1'b1);
    push(5'd3, 32'd2, 0);          cyc(r_ins(5'd1, 5'd2, 5'd3, 6'b100000), 1'b1);
    push(5'd4, 32'd1, 0);          cyc(r_ins(5'd2, 5'd1, 5'd4, 6'b101010), 1'b1);
    push(5'd5, 32'd0, 0);          cyc(r_ins(5'd1, 5'd1, 5'd5, 6'b100010), 1'b1);
    push(5'd0, 32'd0, 1);          cyc(r_ins(5'd1, 5'd1, 5'd0, 6'b100000), 1'b1);
    chk("r0_wb_valid", {31'b0, wb_valid}, 32'd1);
    push(5'd7, 32'd5, 0);          cyc(r_ins(5'd0, 5'd1, 5'd7, 6'b100000), 1'b1);
    push(5'd8, 32'd7, 0);          cyc(r_ins(5'd1, 5'd3, 5'd8, 6'b100101), 1'b1);

    // store
    cyc(i_ins(6'b101011, 5'd0, 5'd1, 16'd8), 1'b1);
    chk("sw_we",    {31'b0, dmem_we}, 32'd1);
    chk("sw_addr",  {26'b0, dmem_addr}, 32'd2);
    chk("sw_wdata", dmem_wdata, 32'd5);
    chk("sw_no_wb", {31'b0, wb_valid}, 32'd0);
    cyc(32'd0, 1'b0);
    chk("sw_pulse", {31'b0, dmem_we}, 32'd0);

    // load; the instruction offered during LOAD_WB must be ignored
    dmem_rdata = 32'd5;
    push(5'd6, 32'd5, 0);
    cyc(i_ins(6'b100011, 5'd0, 5'd6, 16'd8), 1'b1);
    chk("lw_stall",  {31'b0, stall},    32'd1);
    chk("lw_re",     {31'b0, dmem_re},  32'd1);
    chk("lw_addr",   {26'b0, dmem_addr}, 32'd2);
    chk("lw_no_wb",  {31'b0, wb_valid}, 32'd0);
    cyc(i_ins(6'b001000, 5'd0, 5'd9, 16'd77), 1'b1);
    chk("lw_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("lw_unstall",  {31'b0, stall},    32'd0);
    chk("lw_re_pulse", {31'b0, dmem_re},  32'd0);
    push(5'd10, 32'd0, 0);         cyc(r_ins(5'd9, 5'd0, 5'd10, 6'b100000), 1'b1);

    // branch / jump
    cyc(i_ins(6'b000100, 5'd1, 5'd1, 16'd4), 1'b1);
    chk("beq_eq_branch", {31'b0, branch}, 32'd1);
    chk("beq_eq_zero",   {31'b0, zero},   32'd1);
    cyc(32'd0, 1'b0);
    chk("beq_hold_branch", {31'b0, branch}, 32'd1);
    chk("beq_hold_zero",   {31'b0, zero},   32'd1);
    cyc(i_ins(6'b000100, 5'd1, 5'd2, 16'd4), 1'b1);
    chk("beq_ne_branch", {31'b0, branch}, 32'd1);
    chk("beq_ne_zero",   {31'b0, zero},   32'd0);
    push(5'd11, 32'd10, 0);        cyc(r_ins(5'd1, 5'd1, 5'd11, 6'b100000), 1'b1);
    chk("add_branch_clr", {31'b0, branch}, 32'd0);
    cyc({6'b000010, 26'd100}, 1'b1);
    chk("j_jump",   {31'b0, jump},   32'd1);
    chk("j_branch", {31'b0, branch}, 32'd0);

    // illegal
    chk("pre_illegal", {31'b0, illegal}, 32'd0);
    cyc({6'b111111, 26'd0}, 1'b1);
    chk("ill_flag",   {31'b0, illegal},  32'd1);
    chk("ill_no_wb",  {31'b0, wb_valid}, 32'd0);
    chk("ill_jump",   {31'b0, jump},     32'd0);
    push(5'd12, 32'd1, 0);         cyc(i_ins(6'b001000, 5'd0, 5'd12, 16'd1), 1'b1);
    chk("ill_sticky", {31'b0, illegal}, 32'd1);
    cyc(r_ins(5'd1, 5'd1, 5'd13, 6'b000111), 1'b1);
    chk("ill_funct_no_wb", {31'b0, wb_valid}, 32'd0);

    // reset during LOAD_WB
    dmem_rdata = 32'd123;
    cyc(i_ins(6'b100011, 5'd0, 5'd13, 16'd0), 1'b1);
    chk("lw2_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("abort_stall",    {31'b0, stall},    32'd0);
    chk("abort_illegal",  {31'b0, illegal},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(5'd14, 32'd0, 0);         cyc(r_ins(5'd1, 5'd0, 5'd14, 6'b100000), 1'b1);
    push(5'd15, 32'd0, 0);         cyc(r_ins(5'd13, 5'd2, 5'd15, 6'b100101), 1'b1);
    cyc(32'd0, 1'b0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_execute.md
Name: decode_execute

Overview:
- Second stage of the 2-stage processor.
- Consumes the 32-bit instruction and PC that the fetch stage updates on negedge clk.
- Decodes, reads the register file, executes in the ALU, and performs data-memory access and writeback.
- Drives the branch, zero and jump controls back to fetch, plus a stall request for multi-cycle loads.

Parameters:
- NREG, 32, number of architectural registers (r0 hard-wired to 0).
- DW, 32, datapath width.
- DMEM_AW, 6, data-memory word-address width.

Ports:
- clk  input  1  stage clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset.
- instr  input  32  instruction from fetch.
- pc  input  32  PC of that instruction.
- instr_valid  input  1  instr/pc hold a new instruction this cycle.
- branch  output  1  current instruction is beq.
- zero  output  1  beq operands are equal.
- jump  output  1  current instruction is j.
- stall  output  1  fetch must hold its PC and instr.
- dmem_addr  output  DMEM_AW  data-memory word address.
- dmem_wdata  output  DW  store data.
- dmem_we  output  1  store strobe.
- dmem_re  output  1  load strobe.
- dmem_rdata  input  DW  load data, valid one cycle after dmem_re.
- wb_valid  output  1  register write happened this cycle.
- wb_reg  output  5  destination register written.
- wb_data  output  DW  value written.
- illegal  output  1  sticky flag: unsupported opcode or funct seen.

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0, FSM to EXEC, all registers cleared to 0, illegal cleared. Reset mid-load aborts the load with no writeback.
- Decode fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0], sign-extended to DW.
- Supported instructions:
  - R-type (op 000000), funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed compare).
  - addi 001000, lw 100011, sw 101011, beq 000100, j 000010.
  - Any other op or funct: executes as a NOP and sets illegal (stays set until reset).
- Arithmetic is modulo 2^DW; overflow is ignored.
- Data-memory addressing: the byte address is rs+imm, and dmem_addr is byte address [DMEM_AW+1:2]. Low two address bits are ignored.
- r0 writes are discarded: wb_valid still pulses, but the register stays 0.
- FSM, EXEC state, on posedge with instr_valid=1:
  - R-type / addi: write rd / rt. wb_valid=1 in the same cycle (single-cycle latency).
  - sw: dmem_we=1 for exactly one cycle, dmem_wdata=rt value, no writeback.
  - beq: branch=1, zero=(rs==rt). Both are registered and held until the next accepted instruction, so fetch sees them on the following negedge.
  - j: jump=1, same hold rule as branch.
  - lw: dmem_re=1, stall=1, latch rt, go to LOAD_WB.
- FSM, LOAD_WB state: write dmem_rdata to the latched rt, wb_valid=1, stall=0, return to EXEC. instr_valid is ignored while in this state.
- Outputs for non-matching instructions: branch, zero and jump are 0 for every accepted instruction that is not beq / j.
- instr_valid=0 in EXEC: no state change, no strobes; branch, zero and jump hold.
- Pulse outputs: wb_valid, dmem_we and dmem_re are single-cycle pulses.
- Read-after-write: register reads in the same cycle as a write to the same register return the old value. Fetch's one-instruction spacing guarantees the write is visible to the next instruction.

Decomposition:
- Shared package proc_pkg holds:
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J;
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT;
  - ALU op enum alu_op_t;
  - FSM state enum de_state_t {EXEC, LOAD_WB}.
- One sub-module is natural: regfile (NREG x DW, 2 combinational read ports, 1 synchronous write port, synchronous active-low clear).

Test Plan:
- Reset, then addi r1,r0,5 and addi r2,r0,-3 -> wb_data 5 then 0xFFFFFFFD; add r3,r1,r2 -> r3=2.
- slt r4,r2,r1 -> r4=1; sub r5,r1,r1 -> 0; add writing r0 -> wb_valid=1, later read of r0 returns 0.
- sw r1,8(r0) -> dmem_we=1, dmem_addr=2, dmem_wdata=5. Then lw r6,8(r0) with memory returning 5 -> stall=1 for one cycle, next cycle wb_reg=6, wb_data=5.
- beq r1,r1 -> branch=1, zero=1; beq r1,r2 -> branch=1, zero=0; following add -> branch=0. j -> jump=1.
- Opcode 111111 -> no writeback, illegal=1 and stays set across later valid instructions until rst_n=0.
- rst_n=0 asserted during LOAD_WB -> no wb_valid, stall=0, all registers read 0 after reset.
